// File: rtl/apb_ucpd_sync_filt.sv
// Multi-channel synchronizer + programmable glitch filter + registered rise/fall pulses for UCPD rx/status lines.
// Latency: data_d follows a stable data_s change F_SYNC_TYPE+filt_thr+1 clk_d edges after the change is set up.
// Backpressure: none; free-running sampler, every cycle produces a result.
//
// Ports:
//   clk_d     destination-domain clock
//   rst_d     synchronous reset, active high (priority over init_d_n)
//   init_d_n  synchronous re-initialise, active low; same effect as rst_d
//   data_s    CH asynchronous inputs
//   filt_thr  filter threshold (0 = pass-through after sync); may change live
//   data_d    CH filtered, synchronized levels
//   rise_d    CH one-cycle pulses on data_d 0->1
//   fall_d    CH one-cycle pulses on data_d 1->0
//   chg_d     OR of all rise_d/fall_d bits, registered alongside them
module apb_ucpd_sync_filt #(
  parameter int              CH          = 4,
  parameter logic [CH-1:0]   RST_VAL     = '0,
  parameter int              F_SYNC_TYPE = 2,
  parameter int              FILT_W      = 4
) (
  input  logic              clk_d,
  input  logic              rst_d,
  input  logic              init_d_n,
  input  logic [CH-1:0]     data_s,
  input  logic [FILT_W-1:0] filt_thr,
  output logic [CH-1:0]     data_d,
  output logic [CH-1:0]     rise_d,
  output logic [CH-1:0]     fall_d,
  output logic              chg_d
);

  // Synchronizer stages; stage F_SYNC_TYPE-1 is the metastability-safe copy.
  logic [CH-1:0]     sync_q [F_SYNC_TYPE];
  logic [CH-1:0]     ss;
  logic [FILT_W-1:0] cnt_q   [CH];
  logic [FILT_W-1:0] cnt_nxt [CH];
  logic [CH-1:0]     commit;

  assign ss = sync_q[F_SYNC_TYPE-1];

  // Filter decision per channel. The >= compare (rather than ==) lets a live
  // threshold drop below the running count commit immediately; the counter
  // only increments while strictly below the threshold, so it cannot wrap.
  always_comb begin
    commit = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_nxt[i] = '0;
      if (ss[i] != data_d[i]) begin
        if (cnt_q[i] >= filt_thr) begin
          commit[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_d) begin
    if (rst_d || !init_d_n) begin
      for (int k = 0; k < F_SYNC_TYPE; k++) begin
        sync_q[k] <= RST_VAL;
      end
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
      data_d <= RST_VAL;
      rise_d <= '0;
      fall_d <= '0;
      chg_d  <= 1'b0;
    end else begin
      sync_q[0] <= data_s;
      for (int k = 1; k < F_SYNC_TYPE; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_nxt[i];
      end
      // A committed channel takes the synchronized level, i.e. flips.
      data_d <= data_d ^ commit;
      rise_d <= commit & ss;
      fall_d <= commit & ~ss;
      chg_d  <= |commit;
    end
  end

endmodule

// File: tb/tb_apb_ucpd_sync_filt.sv
module tb_apb_ucpd_sync_filt;

  localparam int         CH  = 4;
  localparam int         FS  = 2;
  localparam int         FW  = 4;
  localparam logic [3:0] RST = 4'b1010;

  logic          clk = 1'b0;
  logic          rst_d = 1'b1;
  logic          init_d_n = 1'b1;
  logic [3:0]    data_s = RST;
  logic [FW-1:0] filt_thr = '0;
  logic [3:0]    data_d, rise_d, fall_d;
  logic          chg_d;

  int n_checks = 0;
  int n_pass   = 0;

  apb_ucpd_sync_filt #(.CH(CH), .RST_VAL(RST), .F_SYNC_TYPE(FS), .FILT_W(FW)) dut (
    .clk_d   (clk),
    .rst_d   (rst_d),
    .init_d_n(init_d_n),
    .data_s  (data_s),
    .filt_thr(filt_thr),
    .data_d  (data_d),
    .rise_d  (rise_d),
    .fall_d  (fall_d),
    .chg_d   (chg_d)
  );

  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {data_d, rise_d, fall_d, chg_d};

  // Reference model: the input reaches the filter FS edges after capture
  // (a simple delay queue); a channel flips once that delayed level has
  // disagreed with the output for more than filt_thr consecutive edges
  // (judged against the threshold in force at each edge).
  logic [3:0] m_pipe [$];
  logic [3:0] m_data, m_rise, m_fall, m_dly, m_flip;
  logic       m_chg;
  int         m_dis [4];
  logic [12:0] m_obs;
  assign m_obs = {m_data, m_rise, m_fall, m_chg};

  always @(posedge clk) begin
    if (rst_d || !init_d_n) begin
      m_pipe = {};
      for (int k = 0; k < FS; k++) m_pipe.push_back(RST);
      m_data = RST; m_rise = '0; m_fall = '0; m_chg = 1'b0;
      for (int i = 0; i < 4; i++) m_dis[i] = 0;
    end else begin
      m_dly  = m_pipe[FS-1];
      m_flip = '0;
      for (int i = 0; i < 4; i++) begin
        if (m_dly[i] == m_data[i]) m_dis[i] = 0;
        else if (m_dis[i] >= int'(filt_thr)) begin
          m_flip[i] = 1'b1;
          m_dis[i]  = 0;
        end else m_dis[i] = m_dis[i] + 1;
      end
      m_rise = m_flip & m_dly;
      m_fall = m_flip & ~m_dly;
      m_chg  = (m_flip != 4'b0);
      m_data = m_data ^ m_flip;
      m_pipe.push_front(data_s);
      void'(m_pipe.pop_back());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_d = 1'b1;
    tick();
    tick();
    n_checks++;
    if (obs !== {RST, 4'b0, 4'b0, 1'b0}) $display("FAIL reset_state: got %b want %b", obs, {RST, 9'b0});
    else n_pass++;
    rst_d = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (obs !== {RST, 4'b0, 4'b0, 1'b0}) $display("FAIL reset_idle: got %b want %b", obs, {RST, 9'b0});
    else n_pass++;
  endtask

  task automatic test_latency();
    filt_thr = 4'd0;
    data_s   = 4'b1011;
    tick(); tick();
    n_checks++;
    if (obs !== {4'b1010, 4'b0, 4'b0, 1'b0}) $display("FAIL lat_edge2: got %b want %b", obs, {4'b1010, 9'b0});
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== {4'b1011, 4'b0001, 4'b0, 1'b1}) $display("FAIL lat_edge3: got %b want %b", obs, {4'b1011, 4'b0001, 4'b0, 1'b1});
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== {4'b1011, 4'b0, 4'b0, 1'b0}) $display("FAIL lat_edge4: got %b want %b", obs, {4'b1011, 9'b0});
    else n_pass++;
  endtask

  task automatic test_glitch();
    data_s = 4'b1001;
    repeat (5) tick();
    filt_thr = 4'd3;
    data_s   = 4'b1011;
    repeat (3) tick();
    data_s   = 4'b1001;
    for (int e = 4; e <= 10; e++) begin
      tick();
      n_checks++;
      if (obs !== {4'b1001, 4'b0, 4'b0, 1'b0}) $display("FAIL glitch3_edge%0d: got %b want %b", e, obs, {4'b1001, 9'b0});
      else n_pass++;
    end
    data_s = 4'b1011;
    repeat (4) tick();
    data_s = 4'b1001;
    tick();
    n_checks++;
    if (obs !== {4'b1001, 4'b0, 4'b0, 1'b0}) $display("FAIL glitch4_edge5: got %b want %b", obs, {4'b1001, 9'b0});
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== {4'b1011, 4'b0010, 4'b0, 1'b1}) $display("FAIL glitch4_rise: got %b want %b", obs, {4'b1011, 4'b0010, 4'b0, 1'b1});
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (obs !== {4'b1011, 4'b0, 4'b0, 1'b0}) $display("FAIL glitch4_edge9: got %b want %b", obs, {4'b1011, 9'b0});
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== {4'b1001, 4'b0, 4'b0010, 1'b1}) $display("FAIL glitch4_fall: got %b want %b", obs, {4'b1001, 4'b0, 4'b0010, 1'b1});
    else n_pass++;
  endtask

  task automatic test_thr_change();
    filt_thr = 4'd7;
    data_s   = 4'b1101;
    repeat (7) tick();
    n_checks++;
    if (obs !== {4'b1001, 4'b0, 4'b0, 1'b0}) $display("FAIL thr_hold: got %b want %b", obs, {4'b1001, 9'b0});
    else n_pass++;
    filt_thr = 4'd2;
    tick();
    n_checks++;
    if (obs !== {4'b1101, 4'b0100, 4'b0, 1'b1}) $display("FAIL thr_commit: got %b want %b", obs, {4'b1101, 4'b0100, 4'b0, 1'b1});
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== {4'b1101, 4'b0, 4'b0, 1'b0}) $display("FAIL thr_one_pulse: got %b want %b", obs, {4'b1101, 9'b0});
    else n_pass++;
  endtask

  task automatic test_init();
    filt_thr = 4'd0;
    data_s   = RST;
    repeat (6) tick();
    filt_thr = 4'd4;
    data_s   = 4'b0010;
    repeat (4) tick();
    init_d_n = 1'b0;
    tick();
    init_d_n = 1'b1;
    n_checks++;
    if (obs !== {RST, 4'b0, 4'b0, 1'b0}) $display("FAIL init_state: got %b want %b", obs, {RST, 9'b0});
    else n_pass++;
    repeat (6) tick();
    n_checks++;
    if (obs !== {RST, 4'b0, 4'b0, 1'b0}) $display("FAIL init_requal_wait: got %b want %b", obs, {RST, 9'b0});
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== {4'b0010, 4'b0, 4'b1000, 1'b1}) $display("FAIL init_requal: got %b want %b", obs, {4'b0010, 4'b0, 4'b1000, 1'b1});
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    filt_thr = 4'd0;
    data_s   = 4'b0000;
    repeat (6) tick();
    filt_thr = 4'd1;
    data_s   = 4'b1111;
    repeat (3) tick();
    n_checks++;
    if (obs !== {4'b0000, 4'b0, 4'b0, 1'b0}) $display("FAIL simul_wait: got %b want %b", obs, 13'b0);
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== {4'b1111, 4'b1111, 4'b0, 1'b1}) $display("FAIL simul_rise: got %b want %b", obs, {4'b1111, 4'b1111, 4'b0, 1'b1});
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== {4'b1111, 4'b0, 4'b0, 1'b0}) $display("FAIL simul_single: got %b want %b", obs, {4'b1111, 9'b0});
    else n_pass++;
    filt_thr = 4'd0;
    data_s   = 4'b0000;
    repeat (6) tick();
    filt_thr = 4'd1;
    data_s   = 4'b1111;
    repeat (3) tick();
    rst_d = 1'b1;
    tick();
    rst_d = 1'b0;
    n_checks++;
    if (obs !== {RST, 4'b0, 4'b0, 1'b0}) $display("FAIL simul_rst: got %b want %b", obs, {RST, 9'b0});
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(63) == 0) filt_thr = 4'($urandom_range(5));
      init_d_n = ($urandom_range(149) != 0);
      rst_d    = ($urandom_range(299) == 0);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(3) == 0) data_s[i] = ~data_s[i];
      tick();
      n_checks++;
      if (obs !== m_obs) begin
        if (errs < 10) $display("FAIL random_cycle%0d: got %b want %b", c, obs, m_obs);
        errs++;
      end else n_pass++;
    end
    rst_d = 1'b0;
    init_d_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_thr_change();
    test_init();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
